// File: rtl/ptr_local_ni.sv
// ptr_local_ni: local network interface between a processing node and the
// local port of its ring router.
//
// TX path: each node request is checked against the ring, its destination ID
// is turned into a hop count, and the request is queued in a small FIFO. The
// FIFO head is written into the router's local-to-ring buffer whenever that
// buffer has room.
// RX path: the router's show-ahead ring-to-local buffer is drained into a
// single registered valid/ready output stage.
// Two wrap-around counters track packets written to the router and packets
// delivered to the node.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   txVld/txRdy           node TX request handshake
//   txDestId, txDat       TX destination node ID and payload
//   txErr                 one-cycle pulse when an illegal request is dropped
//   rxVld/rxRdy, rxDat    registered RX payload to the node
//   l2rWr, l2rFul         write strobe / full flag of the router L2R buffer
//   l2rDat, destCnt       payload and hop count to the router (qualified by l2rWr)
//   r2lPktVld, r2lDat     router R2L buffer not-empty flag and head payload
//   r2lRd                 pop strobe for the router R2L buffer
//   txPktCnt, rxPktCnt    packets written to the router / delivered to the node
module ptr_local_ni #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NODE_NUM   = 8,
  parameter int unsigned NODE_ID    = 0,
  parameter int unsigned TX_DEPTH   = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned AW        = $clog2(NODE_NUM),
  localparam int unsigned IDW       = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  txVld,
  output logic                  txRdy,
  input  logic [IDW-1:0]        txDestId,
  input  logic [DATA_WIDTH-1:0] txDat,
  output logic                  txErr,
  output logic                  rxVld,
  input  logic                  rxRdy,
  output logic [DATA_WIDTH-1:0] rxDat,
  output logic                  l2rWr,
  input  logic                  l2rFul,
  output logic [DATA_WIDTH-1:0] l2rDat,
  output logic [AW-1:0]         destCnt,
  input  logic                  r2lPktVld,
  input  logic [DATA_WIDTH-1:0] r2lDat,
  output logic                  r2lRd,
  output logic [CNT_WIDTH-1:0]  txPktCnt,
  output logic [CNT_WIDTH-1:0]  rxPktCnt
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;

  // TX FIFO storage and bookkeeping
  logic [AW-1:0]         hop_mem [TX_DEPTH];
  logic [DATA_WIDTH-1:0] dat_mem [TX_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fire;
  logic                  legal;
  logic                  push;
  logic                  pop;
  logic [IDW:0]          diff;
  logic [AW-1:0]         hop;

  // Destination legality and hop count; a single conditional add folds the
  // negative difference back into 1..NODE_NUM-1.
  always_comb begin
    legal = (txDestId < IDW'(NODE_NUM)) && (txDestId != IDW'(NODE_ID));
    diff  = {1'b0, txDestId} - (IDW+1)'(NODE_ID);
    if (diff[IDW]) begin
      diff = diff + (IDW+1)'(NODE_NUM);
    end
    hop = AW'(diff);
  end

  // txRdy looks at the pre-pop occupancy, so a full FIFO refuses even while draining
  assign fifo_full  = (count == CW'(TX_DEPTH));
  assign fifo_empty = (count == '0);
  assign txRdy      = !fifo_full;
  assign fire       = txVld && txRdy;
  assign push       = fire && legal;

  // Drain toward the router straight from the FIFO head
  assign l2rWr   = !fifo_empty && !l2rFul;
  assign pop     = l2rWr;
  assign l2rDat  = dat_mem[rd_ptr];
  assign destCnt = hop_mem[rd_ptr];

  // FIFO payload storage; contents are don't-care while the entry is unoccupied
  always_ff @(posedge clk) begin
    if (push) begin
      hop_mem[wr_ptr] <= hop;
      dat_mem[wr_ptr] <= txDat;
    end
  end

  // FIFO pointers, occupancy and illegal-request pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      txErr  <= 1'b0;
    end else begin
      txErr <= fire && !legal;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // RX stage refills whenever it is empty or being emptied this cycle
  assign r2lRd = r2lPktVld && (!rxVld || rxRdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      rxVld <= 1'b0;
      rxDat <= '0;
    end else if (r2lRd) begin
      rxVld <= 1'b1;
      rxDat <= r2lDat;
    end else if (rxRdy) begin
      rxVld <= 1'b0;
    end
  end

  // Wrap-around packet counters
  always_ff @(posedge clk) begin
    if (rst) begin
      txPktCnt <= '0;
      rxPktCnt <= '0;
    end else begin
      if (l2rWr) begin
        txPktCnt <= txPktCnt + CNT_WIDTH'(1);
      end
      if (rxVld && rxRdy) begin
        rxPktCnt <= rxPktCnt + CNT_WIDTH'(1);
      end
    end
  end

  // Interface sanity properties
  a_no_wr_when_full: assert property (@(posedge clk) disable iff (rst) !(l2rWr && l2rFul));
  a_no_rd_when_empty: assert property (@(posedge clk) disable iff (rst) !(r2lRd && !r2lPktVld));
  a_hop_nonzero: assert property (@(posedge clk) disable iff (rst) !(l2rWr && (destCnt == '0)));

endmodule

// File: tb/tb_ptr_local_ni.sv
// Directed self-checking bench for ptr_local_ni (NODE_NUM=8, NODE_ID=5,
// TX_DEPTH=4, CNT_WIDTH=4 so counter wrap is reachable quickly).
module tb_ptr_local_ni;

  localparam int unsigned DW  = 32;
  localparam int unsigned NN  = 8;
  localparam int unsigned NID = 5;
  localparam int unsigned TD  = 4;
  localparam int unsigned CNW = 4;
  localparam int unsigned AW  = $clog2(NN);
  localparam int unsigned IDW = AW + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           txVld;
  logic           txRdy;
  logic [IDW-1:0] txDestId;
  logic [DW-1:0]  txDat;
  logic           txErr;
  logic           rxVld;
  logic           rxRdy;
  logic [DW-1:0]  rxDat;
  logic           l2rWr;
  logic           l2rFul;
  logic [DW-1:0]  l2rDat;
  logic [AW-1:0]  destCnt;
  logic           r2lPktVld;
  logic [DW-1:0]  r2lDat;
  logic           r2lRd;
  logic [CNW-1:0] txPktCnt;
  logic [CNW-1:0] rxPktCnt;

  int checks = 0;
  int errors = 0;

  ptr_local_ni #(
    .DATA_WIDTH(DW),
    .NODE_NUM  (NN),
    .NODE_ID   (NID),
    .TX_DEPTH  (TD),
    .CNT_WIDTH (CNW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .txVld    (txVld),
    .txRdy    (txRdy),
    .txDestId (txDestId),
    .txDat    (txDat),
    .txErr    (txErr),
    .rxVld    (rxVld),
    .rxRdy    (rxRdy),
    .rxDat    (rxDat),
    .l2rWr    (l2rWr),
    .l2rFul   (l2rFul),
    .l2rDat   (l2rDat),
    .destCnt  (destCnt),
    .r2lPktVld(r2lPktVld),
    .r2lDat   (r2lDat),
    .r2lRd    (r2lRd),
    .txPktCnt (txPktCnt),
    .rxPktCnt (rxPktCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs driven after this are stable for a full cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    txVld     = 1'b0;
    txDestId  = '0;
    txDat     = '0;
    rxRdy     = 1'b0;
    l2rFul    = 1'b0;
    r2lPktVld = 1'b0;
    r2lDat    = '0;

    // Reset state
    do_reset();
    #1;
    check("rst_txRdy", 32'(txRdy), 32'd1);
    check("rst_rxVld", 32'(rxVld), 32'd0);
    check("rst_txErr", 32'(txErr), 32'd0);
    check("rst_l2rWr", 32'(l2rWr), 32'd0);
    check("rst_r2lRd", 32'(r2lRd), 32'd0);
    check("rst_txcnt", 32'(txPktCnt), 32'd0);
    check("rst_rxcnt", 32'(rxPktCnt), 32'd0);

    // Hop-count wrap: dest 2 -> hop 5, dest 7 -> hop 2
    do_reset();
    txVld = 1'b1; txDestId = 4'd2; txDat = 32'hA5;
    tick();
    txDestId = 4'd7; txDat = 32'hB6;
    #1;
    check("hop1_wr", 32'(l2rWr), 32'd1);
    check("hop1_cnt", 32'(destCnt), 32'd5);
    check("hop1_dat", l2rDat, 32'hA5);
    tick();
    txVld = 1'b0;
    #1;
    check("hop2_wr", 32'(l2rWr), 32'd1);
    check("hop2_cnt", 32'(destCnt), 32'd2);
    check("hop2_dat", l2rDat, 32'hB6);
    tick();
    #1;
    check("hop_idle", 32'(l2rWr), 32'd0);
    check("hop_txcnt", 32'(txPktCnt), 32'd2);

    // Illegal destinations: own ID, then out of range
    do_reset();
    txVld = 1'b1; txDestId = 4'd5; txDat = 32'h1;
    tick();
    txDestId = 4'd9; txDat = 32'h2;
    #1;
    check("ill1_wr", 32'(l2rWr), 32'd0);
    check("ill1_err", 32'(txErr), 32'd1);
    tick();
    txVld = 1'b0;
    #1;
    check("ill2_wr", 32'(l2rWr), 32'd0);
    check("ill2_err", 32'(txErr), 32'd1);
    tick();
    #1;
    check("ill_err_clr", 32'(txErr), 32'd0);
    check("ill_txcnt", 32'(txPktCnt), 32'd0);
    txVld = 1'b1; txDestId = 4'd6; txDat = 32'hC3;
    tick();
    txVld = 1'b0;
    #1;
    check("ill_next_wr", 32'(l2rWr), 32'd1);
    check("ill_next_cnt", 32'(destCnt), 32'd1);
    check("ill_next_dat", l2rDat, 32'hC3);
    tick();
    #1;
    check("ill_next_txcnt", 32'(txPktCnt), 32'd1);

    // Backpressure: four fit, the fifth is refused, then ordered drain
    do_reset();
    l2rFul = 1'b1;
    for (int i = 0; i < 5; i++) begin
      txVld = 1'b1; txDestId = 4'd0; txDat = 32'h100 + 32'(i);
      #1;
      check("bp_txRdy", 32'(txRdy), (i < 4) ? 32'd1 : 32'd0);
      check("bp_hold_wr", 32'(l2rWr), 32'd0);
      tick();
    end
    txVld = 1'b0;
    l2rFul = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_drain_wr", 32'(l2rWr), 32'd1);
      check("bp_drain_dat", l2rDat, 32'h100 + 32'(i));
      check("bp_drain_cnt", 32'(destCnt), 32'd3);
      if (i == 0) begin
        check("bp_full_pop_rdy", 32'(txRdy), 32'd0);
      end
      tick();
    end
    #1;
    check("bp_done_wr", 32'(l2rWr), 32'd0);
    check("bp_done_rdy", 32'(txRdy), 32'd1);
    check("bp_txcnt", 32'(txPktCnt), 32'd4);

    // RX stall, then release
    do_reset();
    rxRdy = 1'b0; r2lPktVld = 1'b1; r2lDat = 32'h11;
    #1;
    check("rx_rd1", 32'(r2lRd), 32'd1);
    tick();
    r2lDat = 32'h22;
    #1;
    check("rx_stall_rd", 32'(r2lRd), 32'd0);
    check("rx_stall_vld", 32'(rxVld), 32'd1);
    check("rx_stall_dat", rxDat, 32'h11);
    tick();
    #1;
    check("rx_stall2_rd", 32'(r2lRd), 32'd0);
    check("rx_stall2_dat", rxDat, 32'h11);
    rxRdy = 1'b1;
    #1;
    check("rx_rel_rd", 32'(r2lRd), 32'd1);
    tick();
    r2lPktVld = 1'b0;
    #1;
    check("rx_d2_vld", 32'(rxVld), 32'd1);
    check("rx_d2_dat", rxDat, 32'h22);
    check("rx_d2_cnt", 32'(rxPktCnt), 32'd1);
    tick();
    #1;
    check("rx_end_vld", 32'(rxVld), 32'd0);
    check("rx_end_cnt", 32'(rxPktCnt), 32'd2);
    rxRdy = 1'b0;

    // Reset mid-operation discards queued TX entries and the RX register
    do_reset();
    l2rFul = 1'b1;
    r2lPktVld = 1'b1; r2lDat = 32'h55;
    for (int i = 0; i < 3; i++) begin
      txVld = 1'b1; txDestId = 4'd6; txDat = 32'hD0 + 32'(i);
      tick();
      r2lPktVld = 1'b0;
    end
    txVld = 1'b0;
    #1;
    check("mid_pre_rxVld", 32'(rxVld), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    l2rFul = 1'b0;
    #1;
    check("mid_txRdy", 32'(txRdy), 32'd1);
    check("mid_rxVld", 32'(rxVld), 32'd0);
    check("mid_l2rWr", 32'(l2rWr), 32'd0);
    check("mid_txcnt", 32'(txPktCnt), 32'd0);
    check("mid_rxcnt", 32'(rxPktCnt), 32'd0);
    tick();
    #1;
    check("mid_stale_wr", 32'(l2rWr), 32'd0);
    check("mid_stale_cnt", 32'(txPktCnt), 32'd0);

    // Counter wrap: 17 packets through a 4-bit counter, streaming one per cycle
    do_reset();
    for (int i = 0; i < 17; i++) begin
      txVld = 1'b1; txDestId = 4'd1; txDat = 32'(i);
      #1;
      check("wrap_txRdy", 32'(txRdy), 32'd1);
      if (i == 1) begin
        check("wrap_hop", 32'(destCnt), 32'd4);
        check("wrap_dat", l2rDat, 32'd0);
      end
      tick();
    end
    txVld = 1'b0;
    tick();
    #1;
    check("wrap_idle", 32'(l2rWr), 32'd0);
    check("wrap_txcnt", 32'(txPktCnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptr_local_ni.md
Name: ptr_local_ni

Overview:
- Local network interface between a processing node and its ring router's local port.
- TX side: accepts node requests (destination node ID plus payload), converts the ID into a hop count, buffers requests, and writes them into the router's local-to-ring buffer.
- RX side: drains the router's ring-to-local buffer into a registered valid/ready output.
- Keeps wrap-around packet counters and flags illegal destinations.

Parameters:
- DATA_WIDTH, 32, payload width; must equal the router's data width.
- NODE_NUM, 8, number of ring nodes, ≥2.
- NODE_ID, 0, ring position of this node, 0..NODE_NUM-1.
- TX_DEPTH, 4, TX FIFO entries, power of 2, ≥2.
- CNT_WIDTH, 16, width of the packet counters.
- Local widths: AW = $clog2(NODE_NUM). IDW = AW+1, so out-of-range IDs are representable.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- txVld, in, 1: node TX request valid.
- txRdy, out, 1: TX request accepted this cycle when txVld is high.
- txDestId, in, IDW: destination node ID.
- txDat, in, DATA_WIDTH: TX payload.
- txErr, out, 1: one-cycle pulse when an illegal request is dropped.
- rxVld, out, 1: RX payload valid.
- rxRdy, in, 1: node accepts RX payload.
- rxDat, out, DATA_WIDTH: RX payload.
- l2rWr, out, 1: write strobe to the router local-to-ring buffer.
- l2rFul, in, 1: router local-to-ring buffer full.
- l2rDat, out, DATA_WIDTH: payload to router.
- destCnt, out, AW: hop count to router; qualified by l2rWr.
- r2lPktVld, in, 1: router ring-to-local buffer not empty; data is show-ahead.
- r2lDat, in, DATA_WIDTH: head payload of the ring-to-local buffer.
- r2lRd, out, 1: pop the ring-to-local buffer.
- txPktCnt, out, CNT_WIDTH: packets written to the router.
- rxPktCnt, out, CNT_WIDTH: packets delivered to the node.

Behaviour:
- Reset (synchronous, rst high at a clk edge), values after the edge:
  - TX FIFO empty, rxVld=0, txErr=0.
  - Both counters 0.
  - l2rWr=0, r2lRd=0.
  - txRdy=1.
  - rst overrides all other activity in the same cycle. In-flight FIFO or RX-register contents are discarded; no partial writes.
- TX acceptance:
  - txRdy = !txFifoFull. Fire = txVld & txRdy.
  - Legal request: txDestId < NODE_NUM and txDestId != NODE_ID.
  - A legal fire pushes {hop, txDat}.
  - hop = (txDestId - NODE_ID) mod NODE_NUM, computed at IDW+1 bits and reduced with a single conditional add of NODE_NUM. Result is in 1..NODE_NUM-1.
  - An illegal fire is consumed but not pushed. txErr pulses high in the next cycle. Counters are unchanged.
- TX drain:
  - l2rWr = txFifoNotEmpty & !l2rFul, combinational from the FIFO head.
  - l2rDat and destCnt present the head entry. Pop when l2rWr is high.
  - Minimum latency from fire at edge N to l2rWr is one cycle (l2rWr high during cycle N+1).
  - Push and pop in the same cycle are allowed, including when the FIFO is full: txRdy reflects the pre-pop state, so a full FIFO holds txRdy low even while popping. The occupancy counter is unchanged on push+pop.
  - Entries leave in FIFO order; no reordering.
- RX:
  - One output register.
  - r2lRd = r2lPktVld & (!rxVld | rxRdy).
  - On r2lRd, rxDat <= r2lDat and rxVld <= 1.
  - Else if rxRdy, rxVld <= 0.
  - rxDat must hold stable while rxVld & !rxRdy.
  - Sustained throughput is 1 packet/cycle when rxRdy is held high.
- Counters:
  - txPktCnt increments on l2rWr.
  - rxPktCnt increments on rxVld & rxRdy.
  - Both wrap modulo 2^CNT_WIDTH with no saturation.
- l2rWr and r2lRd are independent; both may be high in the same cycle.
- Assertions:
  - l2rWr never high while l2rFul is high.
  - r2lRd never high while r2lPktVld is low.
  - destCnt is never 0 when l2rWr is high.

Test Plan (NODE_NUM=8, NODE_ID=5, TX_DEPTH=4):
- Hop-count wrap: fire destId=2 (0xA5), then destId=7 (0xB6), with l2rFul=0 → two l2rWr strobes in order. First carries destCnt=5, l2rDat=0xA5; second carries destCnt=2, l2rDat=0xB6. txPktCnt=2.
- Illegal destinations: fire destId=5, then destId=9 → no l2rWr, txErr pulses twice, txPktCnt=0. A following destId=6 gives destCnt=1.
- Backpressure: hold l2rFul=1 and fire 5 back-to-back requests → first 4 accepted, txRdy=0 on the 5th. Release l2rFul → 4 writes on consecutive cycles, then txRdy=1.
- RX stall: r2lPktVld=1 with data 0x11, then 0x22, while rxRdy=0 → one r2lRd, rxDat=0x11 held, no further r2lRd. Raise rxRdy → 0x11 then 0x22 delivered on consecutive cycles; rxPktCnt=2.
- Reset mid-operation: 3 entries queued and rxVld=1, assert rst for 1 cycle → next cycle txRdy=1, rxVld=0, l2rWr=0, counters=0. No stale entries are written afterwards.
- Counter wrap: with CNT_WIDTH=4, send 17 packets → txPktCnt=1.
